// File: rtl/write_through_buffer_pkg.sv
// ---------------------------------------------------------------------------
// write_through_buffer_pkg
// Shared cache definitions used by both the write-side buffer and the
// read-side cache: address field positions/widths and the drain FSM encoding.
//
// Address layout (byte address, 11 bits):
//   tag  = addr[10:5]   (6 bits)
//   line = addr[4:3]    (2 bits)
//   blk  = addr[2:0]    (3 bits)
// ---------------------------------------------------------------------------
package write_through_buffer_pkg;

    localparam int TAG_W    = 6;
    localparam int LINE_W   = 2;
    localparam int BLK_W    = 3;

    localparam int TAG_LSB  = 5;
    localparam int LINE_LSB = 3;
    localparam int BLK_LSB  = 0;

    // Drain FSM: IDLE waits for a buffered entry, REQ holds the RAM write
    // until it is acknowledged.
    typedef enum logic {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_t;

endpackage

// File: rtl/write_through_buffer_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Write-buffer FIFO: storage for buffered (address, data) pairs plus head/tail
// pointers and occupancy count. Also compares a probe address against every
// live entry so the read side can detect a pending write to the same byte.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   push, push_addr/data    enqueue at tail (caller guarantees !full)
//   pop                     dequeue head (caller guarantees !empty)
//   head_addr/head_data     oldest entry, combinational
//   count, full, empty      occupancy state (registered)
//   probe_addr, probe_hit   probe_hit=1 when any live entry matches probe_addr
// ---------------------------------------------------------------------------
module wb_fifo #(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic [AW-1:0]              probe_addr,
    output logic                       probe_hit
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]  addr_mem [DEPTH];
    logic [DW-1:0]  data_mem [DEPTH];

    logic [PW-1:0]  head_reg;
    logic [PW-1:0]  tail_reg;
    logic [PW:0]    count_reg;

    logic [DEPTH-1:0] entry_match;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; liveness is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= push_addr;
            data_mem[tail_reg] <= push_data;
        end
    end

    assign head_addr = addr_mem[head_reg];
    assign head_data = data_mem[head_reg];
    assign count     = count_reg;
    assign full      = (count_reg == (PW+1)'(DEPTH));
    assign empty     = (count_reg == '0);

    // An entry is live when its distance from the head is below the count.
    // The head entry stays live while it is being written to RAM, so a read
    // of that address is still flagged until the write is acknowledged.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_probe
            logic [PW-1:0] offset;
            logic          live;
            assign offset          = PW'(gi) - head_reg;
            assign live            = ({1'b0, offset} < count_reg);
            assign entry_match[gi] = live && (addr_mem[gi] == probe_addr);
        end
    endgenerate

    assign probe_hit = |entry_match;

endmodule

// File: rtl/write_through_buffer.sv
// ---------------------------------------------------------------------------
// write_through_buffer
// Write-through store path for a direct-mapped data cache. Each accepted CPU
// write is queued for RAM and, in the following cycle, looked up against the
// tag store; a hit updates the cached byte (no write-allocate on a miss).
// A two-state drain FSM issues buffered writes to RAM in order, with one
// bubble cycle after each acknowledge.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data     CPU write; accepted when wr_req && wr_ready
//   wr_ready                   buffer not full
//   lk_line -> lk_tag/lk_valid tag-store lookup for the write in the lookup stage
//   dc_wr/dc_line/dc_blk/dc_din data-cache byte write on a lookup hit
//   mem_wr/mem_addr/mem_din    RAM write request, held until mem_ack
//   mem_ack                    RAM write completed
//   rd_addr, rd_hazard         read address matches a buffered write
//   idle                       nothing buffered, lookup empty, drain idle
//   count                      number of buffered entries
// ---------------------------------------------------------------------------
module write_through_buffer
    import write_through_buffer_pkg::*;
#(
    parameter int AW    = 11,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_req,
    input  logic [AW-1:0]              wr_addr,
    input  logic [DW-1:0]              wr_data,
    output logic                       wr_ready,
    input  logic [TAG_W-1:0]           lk_tag,
    input  logic                       lk_valid,
    output logic [LINE_W-1:0]          lk_line,
    output logic                       dc_wr,
    output logic [LINE_W-1:0]          dc_line,
    output logic [BLK_W-1:0]           dc_blk,
    output logic [DW-1:0]              dc_din,
    output logic                       mem_wr,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_din,
    input  logic                       mem_ack,
    input  logic [AW-1:0]              rd_addr,
    output logic                       rd_hazard,
    output logic                       idle,
    output logic [$clog2(DEPTH):0]     count
);

    logic          accept;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    logic          lk_vld_reg;
    logic [AW-1:0] lk_addr_reg;
    logic [DW-1:0] lk_data_reg;

    drain_state_t  state_reg;
    drain_state_t  state_next;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // never opens room for a push while full.
    assign wr_ready = !fifo_full;
    assign accept   = wr_req && wr_ready;

    wb_fifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_addr  (wr_addr),
        .push_data  (wr_data),
        .pop        (pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .probe_addr (rd_addr),
        .probe_hit  (rd_hazard)
    );

    // Lookup stage: reloaded on every accept, so back-to-back writes each get
    // their own lookup cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            lk_vld_reg  <= 1'b0;
            lk_addr_reg <= '0;
            lk_data_reg <= '0;
        end else begin
            lk_vld_reg <= accept;
            if (accept) begin
                lk_addr_reg <= wr_addr;
                lk_data_reg <= wr_data;
            end
        end
    end

    assign lk_line = lk_addr_reg[LINE_LSB +: LINE_W];
    assign dc_wr   = lk_vld_reg && lk_valid
                     && (lk_tag == lk_addr_reg[TAG_LSB +: TAG_W]);
    assign dc_line = lk_addr_reg[LINE_LSB +: LINE_W];
    assign dc_blk  = lk_addr_reg[BLK_LSB +: BLK_W];
    assign dc_din  = lk_data_reg;

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= DRAIN_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Returning to IDLE after each acknowledge gives the bubble cycle and
    // lets the registered count settle before the next request.
    always_comb begin
        state_next = state_reg;
        mem_wr     = 1'b0;
        pop        = 1'b0;
        case (state_reg)
            DRAIN_IDLE: begin
                if (!fifo_empty) begin
                    state_next = DRAIN_REQ;
                end
            end
            DRAIN_REQ: begin
                mem_wr = 1'b1;
                if (mem_ack) begin
                    pop        = 1'b1;
                    state_next = DRAIN_IDLE;
                end
            end
            default: begin
                state_next = DRAIN_IDLE;
            end
        endcase
    end

    assign mem_addr = head_addr;
    assign mem_din  = head_data;
    assign idle     = fifo_empty && !lk_vld_reg && (state_reg == DRAIN_IDLE);

endmodule

// File: tb/tb_write_through_buffer.sv
// ---------------------------------------------------------------------------
// tb_write_through_buffer
// Directed scenarios followed by randomized traffic. A monitor on the falling
// edge keeps a reference model (queue of buffered writes, queue of expected
// cache updates) and compares every DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_write_through_buffer;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic           clk;
    logic           reset;
    logic           wr_req;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           wr_ready;
    logic [5:0]     lk_tag;
    logic           lk_valid;
    logic [1:0]     lk_line;
    logic           dc_wr;
    logic [1:0]     dc_line;
    logic [2:0]     dc_blk;
    logic [DW-1:0]  dc_din;
    logic           mem_wr;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_din;
    logic           mem_ack;
    logic [AW-1:0]  rd_addr;
    logic           rd_hazard;
    logic           idle;
    logic [2:0]     count;

    // Tag store model for the four cache lines.
    logic [5:0]     tag_mem [4];
    logic           tag_v   [4];

    assign lk_tag   = tag_mem[lk_line];
    assign lk_valid = tag_v[lk_line];

    write_through_buffer #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .lk_tag    (lk_tag),
        .lk_valid  (lk_valid),
        .lk_line   (lk_line),
        .dc_wr     (dc_wr),
        .dc_line   (dc_line),
        .dc_blk    (dc_blk),
        .dc_din    (dc_din),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_ack   (mem_ack),
        .rd_addr   (rd_addr),
        .rd_hazard (rd_hazard),
        .idle      (idle),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_t;

    typedef struct {
        int            cyc;
        logic [1:0]    line;
        logic [2:0]    blk;
        logic [DW-1:0] din;
    } dc_t;

    mem_t mq[$];   // writes buffered, in acceptance order
    dc_t  dq[$];   // expected cache updates with their due cycle

    int   cyc      = 0;
    bit   prev_nz  = 0;  // buffer was non-empty during the previous cycle
    bit   ack_last = 0;  // a RAM write completed at the previous edge
    bit   acc_last = 0;  // a write was accepted at the previous edge

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            dq.delete();
            prev_nz  = 0;
            ack_last = 0;
            acc_last = 0;
        end else begin
            int   n;
            bit   exp_mw;
            bit   hz;
            mem_t m;
            dc_t  d;
            n = mq.size();
            // The drain issues a request whenever something was buffered in
            // the previous cycle, except for the bubble right after an ack.
            exp_mw = prev_nz && !ack_last;

            check("count",    32'(count),    32'(n));
            check("wr_ready", 32'(wr_ready), 32'(n != DEPTH));
            check("mem_wr",   32'(mem_wr),   32'(exp_mw));
            check("idle",     32'(idle),     32'(n == 0 && !acc_last));

            hz = 0;
            foreach (mq[i]) if (mq[i].addr == rd_addr) hz = 1;
            check("rd_hazard", 32'(rd_hazard), 32'(hz));

            if (dq.size() > 0 && dq[0].cyc == cyc) begin
                d = dq.pop_front();
                check("dc_wr", 32'(dc_wr), 32'd1);
                if (dc_wr) begin
                    check("dc_line", 32'(dc_line), 32'(d.line));
                    check("dc_blk",  32'(dc_blk),  32'(d.blk));
                    check("dc_din",  32'(dc_din),  32'(d.din));
                end
            end else begin
                check("dc_wr", 32'(dc_wr), 32'd0);
            end

            if (exp_mw && n > 0) begin
                check("mem_addr", 32'(mem_addr), 32'(mq[0].addr));
                check("mem_din",  32'(mem_din),  32'(mq[0].data));
                if (mem_ack) begin
                    m = mq.pop_front();
                    $display("ram write addr=0x%03h data=0x%02h", m.addr, m.data);
                end
            end
            ack_last = exp_mw && mem_ack;
            prev_nz  = (n != 0);

            if (wr_req && n != DEPTH) begin
                logic [1:0] ln;
                m.addr = wr_addr;
                m.data = wr_data;
                mq.push_back(m);
                ln = wr_addr[4:3];
                if (tag_v[ln] && tag_mem[ln] == wr_addr[10:5]) begin
                    d.cyc  = cyc + 1;
                    d.line = ln;
                    d.blk  = wr_addr[2:0];
                    d.din  = wr_data;
                    dq.push_back(d);
                end
                acc_last = 1;
            end else begin
                acc_last = 0;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (!idle && k < bound) begin
            step();
            k++;
        end
        check("drain_timeout", 32'(idle), 32'd1);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [5:0] t;
        logic [1:0] l;
        logic [2:0] b;
        t = ($urandom_range(0, 1) == 0) ? 6'h05 : 6'h09;
        l = 2'($urandom_range(0, 3));
        b = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd5;
        return {t, l, b};
    endfunction

    initial begin
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        mem_ack = 1'b0;
        rd_addr = '0;
        for (int i = 0; i < 4; i++) begin
            tag_mem[i] = 6'h00;
            tag_v[i]   = 1'b0;
        end
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_wr_ready",  32'(wr_ready),  32'd1);
        check("rst_dc_wr",     32'(dc_wr),     32'd0);
        check("rst_mem_wr",    32'(mem_wr),    32'd0);
        check("rst_rd_hazard", 32'(rd_hazard), 32'd0);
        check("rst_idle",      32'(idle),      32'd1);
        check("rst_count",     32'(count),     32'd0);

        // Write hit: line 0 holds valid tag 0x05
        tag_mem[0] = 6'h05;
        tag_v[0]   = 1'b1;
        wr_req  = 1'b1; wr_addr = 11'h0A5; wr_data = 8'h3C;
        step();
        wr_req  = 1'b0;
        check("hit_dc_wr",   32'(dc_wr),   32'd1);
        check("hit_dc_line", 32'(dc_line), 32'd0);
        check("hit_dc_blk",  32'(dc_blk),  32'd5);
        check("hit_dc_din",  32'(dc_din),  32'h3C);
        mem_ack = 1'b1;
        wait_idle(50);
        mem_ack = 1'b0;

        // Same write, line invalid: no cache update, RAM still written
        tag_v[0] = 1'b0;
        wr_req  = 1'b1; wr_addr = 11'h0A5; wr_data = 8'h3C;
        step();
        wr_req  = 1'b0;
        check("miss_dc_wr", 32'(dc_wr), 32'd0);
        mem_ack = 1'b1;
        wait_idle(50);
        mem_ack = 1'b0;

        // Five back-to-back writes with RAM stalled: fifth refused
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            wr_addr = rand_addr();
            wr_data = 8'(8'h10 + i);
            step();
        end
        check("full_count",    32'(count),    32'd4);
        check("full_wr_ready", 32'(wr_ready), 32'd0);

        // Full, ack and request in the same cycle: pop only, push next cycle
        wr_addr = 11'h2E8; wr_data = 8'h77;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("popfull_count",    32'(count),    32'd3);
        check("popfull_wr_ready", 32'(wr_ready), 32'd1);
        step();
        wr_req = 1'b0;
        check("refill_count", 32'(count), 32'd4);
        mem_ack = 1'b1;
        wait_idle(50);
        mem_ack = 1'b0;

        // Read hazard on a buffered address, cleared once it drains
        wr_req = 1'b1; wr_addr = 11'h123; wr_data = 8'h5A;
        step();
        wr_req  = 1'b0;
        rd_addr = 11'h123;
        #1;
        check("hz_buffered", 32'(rd_hazard), 32'd1);
        repeat (3) step();
        check("hz_in_req", 32'(rd_hazard), 32'd1);
        check("hz_mem_wr", 32'(mem_wr),    32'd1);
        mem_ack = 1'b1;
        wait_idle(50);
        mem_ack = 1'b0;
        check("hz_cleared", 32'(rd_hazard), 32'd0);
        check("hz_idle",    32'(idle),      32'd1);

        // Reset while a RAM write is outstanding with 3 entries buffered
        for (int i = 0; i < 3; i++) begin
            wr_req  = 1'b1;
            wr_addr = rand_addr();
            wr_data = 8'($urandom);
            step();
        end
        wr_req = 1'b0;
        step();
        check("pre_rst_mem_wr", 32'(mem_wr), 32'd1);
        check("pre_rst_count",  32'(count),  32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_req_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_req_count",  32'(count),  32'd0);
        check("rst_req_idle",   32'(idle),   32'd1);

        // Randomized traffic with a re-randomized tag store per round
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                tag_mem[i] = ($urandom_range(0, 1) == 0) ? 6'h05 : 6'h09;
                tag_v[i]   = 1'($urandom_range(0, 1));
            end
            for (int c = 0; c < 600; c++) begin
                wr_req  = 1'($urandom_range(0, 1));
                wr_addr = rand_addr();
                wr_data = 8'($urandom);
                mem_ack = ($urandom_range(0, 2) != 0);
                rd_addr = rand_addr();
                step();
            end
            wr_req  = 1'b0;
            mem_ack = 1'b1;
            wait_idle(100);
            mem_ack = 1'b0;
        end

        step();
        check("ram_queue_drained", 32'(mq.size()), 32'd0);
        check("dc_queue_drained",  32'(dq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_through_buffer.md
WRITE_THROUGH_BUFFER -- requirements
Module: write_through_buffer

Interface
REQ-001 The block SHALL have parameter AW, default 11, meaning byte-address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning write-buffer entries (power of two).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_req  input  1  CPU write request.
REQ-007 wr_addr  input  AW  CPU write address: tag=[10:5], line=[4:3], blk=[2:0].
REQ-008 wr_data  input  DW  CPU write data.
REQ-009 wr_ready  output  1  buffer can accept; a write is accepted when wr_req && wr_ready.
REQ-010 lk_tag  input  6  tag-store contents for line lk_line, valid combinationally in the same cycle.
REQ-011 lk_valid  input  1  valid bit for line lk_line, same cycle.
REQ-012 lk_line  output  2  line index of the write held in the lookup stage.
REQ-013 dc_wr  output  1  data-cache byte write strobe.
REQ-014 dc_line / dc_blk / dc_din  output  2 / 3 / DW  data-cache write line, block offset and byte.
REQ-015 mem_wr  output  1  RAM write request, held until acknowledged.
REQ-016 mem_addr / mem_din  output  AW / DW  RAM write address and data.
REQ-017 mem_ack  input  1  RAM has completed the current write.
REQ-018 rd_addr  input  AW  address of the pending cache read/refill.
REQ-019 rd_hazard  output  1  rd_addr equals the address of a valid buffered entry.
REQ-020 idle  output  1  buffer empty, lookup stage empty and drain FSM in IDLE.
REQ-021 count  output  clog2(DEPTH)+1  number of buffered entries.

Function
REQ-022 The block SHALL compute wr_ready = !full from registered state; a push while full SHALL NOT occur even if a pop happens in the same cycle.
REQ-023 An accepted write SHALL be pushed into the FIFO tail and loaded into the lookup stage in the same cycle.
REQ-024 The lookup stage SHALL drive lk_line from the registered address; the cycle after acceptance, dc_wr SHALL be 1 for exactly one cycle iff lk_valid && lk_tag == registered tag (write-hit update, no write-allocate).
REQ-025 On a lookup miss, dc_wr SHALL stay 0 and tag/valid state SHALL NOT be changed.
REQ-026 Back-to-back accepted writes SHALL each receive their own lookup cycle (one write per cycle throughput).
REQ-027 The drain FSM SHALL have states IDLE and REQ; IDLE->REQ when count != 0; REQ holds mem_wr=1 with the head entry on mem_addr/mem_din until mem_ack; on mem_ack the head is popped and the FSM returns to IDLE.
REQ-028 One bubble cycle SHALL follow every acknowledged write; drain throughput is therefore at most one write per two cycles.
REQ-029 A write pushed into an empty buffer SHALL appear on mem_wr no earlier than one cycle after acceptance.
REQ-030 A simultaneous push and pop SHALL leave count unchanged; head and tail pointers SHALL wrap modulo DEPTH.
REQ-031 Writes SHALL reach RAM in acceptance order; two writes to one address SHALL both be issued.
REQ-032 rd_hazard SHALL compare full AW bits against every valid entry, including the entry in REQ, combinationally.
REQ-033 mem_ack received outside REQ SHALL be ignored.

Reset
REQ-034 On reset: count=0, pointers=0, FSM=IDLE, lookup stage empty; wr_ready=1, dc_wr=0, mem_wr=0, rd_hazard=0, idle=1.
REQ-035 Reset during REQ SHALL abandon the outstanding RAM write and discard all buffered entries.

Structure
REQ-036 Tag/line/blk field positions and widths and the FSM state encoding SHALL live in a shared cache package used also by the read-side cache.
REQ-037 The FIFO storage and pointers SHALL be one sub-module, wb_fifo; the lookup stage and drain FSM stay in the top.

Verification
REQ-038 Write 0x0A5/0x3C with line 0 holding valid tag 0x05 -> dc_wr=1 next cycle with line 0, blk 5, din 0x3C; mem_wr with 0x0A5/0x3C follows.
REQ-039 Same write with lk_valid=0 -> dc_wr stays 0; RAM still receives 0x0A5/0x3C.
REQ-040 Five writes back-to-back, mem_ack held 0 -> fifth sees wr_ready=0 and is not accepted; count=4.
REQ-041 Buffer full, mem_ack=1 and wr_req=1 same cycle -> pop occurs, push refused that cycle, accepted the next; count ends at 4.
REQ-042 Buffered 0x123, rd_addr=0x123 -> rd_hazard=1; after mem_ack pop -> rd_hazard=0 and idle=1.
REQ-043 reset asserted while mem_wr=1 with 3 entries -> next cycle mem_wr=0, count=0, idle=1.
